// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared types, default constants and helpers for the LED
//             waveform-ROM scheduler (FSM encoding, widths, clog2).
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TICK_DIV   = 520833;

  // Ceiling log2; clog2(1) is 0, callers clamp where a 1-bit minimum is needed.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Channels start evenly spread across one waveform period.
  function automatic int phase_init(input int ch, input int num_ch, input int addr_width);
    return ch * ((1 << addr_width) / num_ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_lut_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_lut_scheduler_if
//  Purpose  : Phase-configuration handshake plus shared waveform-ROM bus.
//             master = host side (drives config, returns ROM data),
//             slave  = scheduler side.
//  Revision : 1.0  initial release
// ============================================================================
interface led_lut_scheduler_if
  import led_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  localparam int CH_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  logic                  in_cfg_valid;
  logic [CH_W-1:0]       in_cfg_ch;
  logic [ADDR_WIDTH-1:0] in_cfg_phase;
  logic                  out_cfg_ready;
  logic [ADDR_WIDTH-1:0] out_rom_addr;
  logic [DATA_WIDTH-1:0] in_rom_data;

  modport master (
    output in_cfg_valid, in_cfg_ch, in_cfg_phase, in_rom_data,
    input  out_cfg_ready, out_rom_addr
  );

  modport slave (
    input  in_cfg_valid, in_cfg_ch, in_cfg_phase, in_rom_data,
    output out_cfg_ready, out_rom_addr
  );

endinterface
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_tick_gen
//  Purpose  : Free-running 0..TICK_DIV-1 counter; tick_o is high for the one
//             cycle in which the counter holds TICK_DIV-1.
//  Revision : 1.0  initial release
// ============================================================================
module led_tick_gen
  import led_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int              CNT_W    = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  // Next count: wrap to zero on the tick cycle.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_lut_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : led_lut_scheduler
//  Purpose  : Time-shares one registered-read waveform ROM among NUM_CH LED
//             channels. Each waveform step tick sweeps all channels: issue
//             base_addr + phase[ch], capture the returned sample one cycle
//             later into that channel's duty register.
//  Options  : LED_SCHED_CFG_EN - when defined, per-channel phases are
//             runtime-writable through the config handshake; otherwise they
//             are constants and out_cfg_ready is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module led_lut_scheduler
  import led_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic                         in_clk,
  input  logic                         in_rst_n,
  input  logic [NUM_CH-1:0]            in_ch_en,
  led_lut_scheduler_if.slave           bus,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_duty,
  output logic [NUM_CH-1:0]            out_duty_valid,
  output logic                         out_sweep_busy
);

  localparam int               IDX_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  // A sweep must finish before the next tick can arrive.
  if (TICK_DIV < NUM_CH + 2) begin : g_bad_tick_div
    $error("led_lut_scheduler: TICK_DIV must be >= NUM_CH+2");
  end
  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("led_lut_scheduler: NUM_CH must be in 2..16");
  end

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  cap_vld_q;
  logic [IDX_W-1:0]      cap_idx_q;
  logic [NUM_CH-1:0]     duty_vld_q;
  logic [DATA_WIDTH-1:0] duty_q [NUM_CH];

  logic                  tick_w;
  logic [ADDR_WIDTH-1:0] phase_w [NUM_CH];
  logic [IDX_W-1:0]      next_idx_d;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [ADDR_WIDTH-1:0] phase_sel_d;
  logic [ADDR_WIDTH-1:0] rom_addr_d;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (in_clk),
    .rst_ni (in_rst_n),
    .tick_o (tick_w)
  );

`ifdef LED_SCHED_CFG_EN
  logic cfg_wr_w;

  assign bus.out_cfg_ready = (state_q == ST_IDLE) && !tick_w;
  assign cfg_wr_w          = bus.out_cfg_ready && bus.in_cfg_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
    logic [ADDR_WIDTH-1:0] phase_q;

    // Phase register; an index with no matching channel simply writes nothing.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        phase_q <= ADDR_WIDTH'(phase_init(g, NUM_CH, ADDR_WIDTH));
      end else if (cfg_wr_w && (bus.in_cfg_ch == IDX_W'(g))) begin
        phase_q <= bus.in_cfg_phase;
      end
    end

    assign phase_w[g] = phase_q;
  end
`else
  logic unused_cfg_w;

  assign bus.out_cfg_ready = 1'b0;
  assign unused_cfg_w      = ^{bus.in_cfg_valid, bus.in_cfg_ch, bus.in_cfg_phase};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
    assign phase_w[g] = ADDR_WIDTH'(phase_init(g, NUM_CH, ADDR_WIDTH));
  end
`endif

  // Address of the channel to present next: channel 0 on the tick edge
  // (using the freshly incremented base), then idx+1 while issuing.
  always_comb begin
    next_idx_d = '0;
    if (state_q == ST_ISSUE) begin
      next_idx_d = idx_q + IDX_W'(1);
    end
    base_d = base_q;
    if (tick_w) begin
      base_d = base_q + ADDR_WIDTH'(1);
    end
    phase_sel_d = phase_w[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_idx_d == IDX_W'(i)) begin
        phase_sel_d = phase_w[i];
      end
    end
    rom_addr_d = base_d + phase_sel_d;
  end

  // Sweep FSM with issue/capture pipeline and registered outputs.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      rom_addr_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      duty_vld_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      base_q     <= base_d;
      cap_vld_q  <= 1'b0;
      duty_vld_q <= '0;

      // ROM data for the channel issued last cycle is on in_rom_data now.
      if (cap_vld_q) begin
        duty_q[cap_idx_q] <= in_ch_en[cap_idx_q] ? bus.in_rom_data : '0;
        duty_vld_q        <= NUM_CH'(1) << cap_idx_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick_w) begin
            state_q    <= ST_ISSUE;
            idx_q      <= '0;
            rom_addr_q <= rom_addr_d;
          end
        end
        ST_ISSUE: begin
          cap_vld_q <= 1'b1;
          cap_idx_q <= idx_q;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DRAIN;
          end else begin
            idx_q      <= next_idx_d;
            rom_addr_q <= rom_addr_d;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_rom_addr = rom_addr_q;
  assign out_duty_valid   = duty_vld_q;
  assign out_sweep_busy   = (state_q != ST_IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_duty_pack
    assign out_duty[g*DATA_WIDTH +: DATA_WIDTH] = duty_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_led_lut_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_lut_scheduler
//  Purpose  : Randomized self-checking bench for led_lut_scheduler against a
//             cycle-table reference model (NUM_CH=4, TICK_DIV=16,
//             ROM data = addr ^ 8'hA5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_lut_scheduler;

  localparam int NUM_CH   = 4;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int TICK_DIV = 16;
`ifdef LED_SCHED_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_CH-1:0]    ch_en = '0;
  logic [NUM_CH*DW-1:0] duty;
  logic [NUM_CH-1:0]    duty_valid;
  logic                 busy;

  led_lut_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  led_lut_scheduler #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_ch_en       (ch_en),
    .bus            (bus),
    .out_duty       (duty),
    .out_duty_valid (duty_valid),
    .out_sweep_busy (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model with one-cycle registered read.
  always @(posedge clk) bus.in_rom_data <= bus.out_rom_addr ^ 8'hA5;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         cyc;
  int         last_tick;
  int         nticks;
  int         last_r;
  logic [7:0] base_sw;
  logic [7:0] phase_m  [NUM_CH];
  logic [7:0] snap     [NUM_CH];
  logic [7:0] exp_duty [NUM_CH];
  logic [7:0] exp_addr;
  logic [3:0] en_prev;

  // Stimulus controls
  int en_mode  = 0;
  bit cfg_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    last_tick = -1000;
    nticks    = 0;
    base_sw   = 8'd0;
    exp_addr  = 8'd0;
    en_prev   = ch_en;
    for (int i = 0; i < NUM_CH; i++) begin
      phase_m[i]  = 8'(i * (256 / NUM_CH));
      snap[i]     = phase_m[i];
      exp_duty[i] = 8'd0;
    end
  endtask

  // Called at the negedge of each cycle: check, drive inputs, advance model.
  task automatic step_body();
    int         r;
    bit         tk;
    logic       exp_busy;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    logic [7:0] a;
    tk       = (cyc % TICK_DIV) == TICK_DIV - 1;
    r        = cyc - last_tick;
    last_r   = r;
    exp_vld  = 4'b0000;
    if (r >= 1 && r <= NUM_CH) begin
      exp_addr = base_sw + snap[r-1];
    end
    if (r >= 3 && r <= NUM_CH + 2) begin
      a = base_sw + snap[r-3];
      exp_duty[r-3] = en_prev[r-3] ? (a ^ 8'hA5) : 8'h00;
      exp_vld = 4'(1 << (r - 3));
    end
    exp_busy = (r >= 1 && r <= NUM_CH + 1);
    exp_rdy  = CFG_EN && !tk && !exp_busy;

    chk("rom_addr",   32'(bus.out_rom_addr), 32'(exp_addr));
    chk("sweep_busy", 32'(busy),             32'(exp_busy));
    chk("duty_valid", 32'(duty_valid),       32'(exp_vld));
    chk("cfg_ready",  32'(bus.out_cfg_ready), 32'(exp_rdy));
    chk("duty",       duty, {exp_duty[3], exp_duty[2], exp_duty[1], exp_duty[0]});

    case (en_mode)
      0:       ch_en = 4'hF;
      1:       ch_en = 4'b1011;
      default: if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom);
    endcase
    bus.in_cfg_ch     = 2'($urandom);
    bus.in_cfg_phase  = 8'($urandom);
    bus.in_cfg_valid  = tk || (cfg_rand && $urandom_range(0, 5) == 0);
    if (cyc == 24) begin
      bus.in_cfg_valid = 1'b1;
      bus.in_cfg_ch    = 2'd1;
      bus.in_cfg_phase = 8'h10;
    end

    if (CFG_EN && bus.in_cfg_valid && exp_rdy) begin
      phase_m[bus.in_cfg_ch] = bus.in_cfg_phase;
    end
    if (tk) begin
      nticks++;
      base_sw   = 8'(nticks);
      snap      = phase_m;
      last_tick = cyc;
    end
    en_prev = ch_en;
    cyc++;
  endtask

  initial begin
    bus.in_cfg_valid = 1'b0;
    bus.in_cfg_ch    = '0;
    bus.in_cfg_phase = '0;
    ch_en            = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step_body();

    en_mode = 0;
    repeat (60) begin @(negedge clk); step_body(); end
    en_mode = 1;
    repeat (48) begin @(negedge clk); step_body(); end
    en_mode  = 2;
    cfg_rand = 1'b1;
    repeat (4200) begin @(negedge clk); step_body(); end

    // Abort a sweep with reset during its cycle 2.
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        step_body();
        if (last_r == 2) found = 1'b1;
      end
      chk("sweep_found", 32'(found), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_duty",       duty,                   32'd0);
    chk("rst_busy",       32'(busy),              32'd0);
    chk("rst_duty_valid", 32'(duty_valid),        32'd0);
    chk("rst_rom_addr",   32'(bus.out_rom_addr),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step_body();
    repeat (40) begin @(negedge clk); step_body(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
